// File: rtl/tt_sel_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// tt_sel_pkg : shared types and defaults for the selection sequencer
// rev 1.0
// ------------------------------------------------------------------
package tt_sel_pkg;

   localparam int CNT_W_DEF      = 10;
   localparam int RST_CYC_DEF    = 4;
   localparam int PULSE_CYC_DEF  = 2;
   localparam int SETTLE_CYC_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DIS      = 3'd1,
      ST_RST      = 3'd2,
      ST_INC_L    = 3'd3,
      ST_INC_H    = 3'd4,
      ST_SETTLE   = 3'd5,
      ST_RST_HOLD = 3'd6
   } sel_state_e;

   // Timer holds (duration - 1), so clog2 of the longest phase is enough.
   function automatic int tmr_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tt_sel_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// tt_sel_timer : loadable down-counter, done while the count is zero
// rev 1.0
// ------------------------------------------------------------------
module tt_sel_timer #(
   parameter int TMR_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [TMR_W-1:0] load_val_i,
   output logic             done_o
);

   logic [TMR_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/tt_sel_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// tt_sel_seq : drives the mux controller select interface to a target
// rev 1.0
// ------------------------------------------------------------------
module tt_sel_seq
   import tt_sel_pkg::*;
#(
   parameter int CNT_W        = CNT_W_DEF,
   parameter int RST_CYC      = RST_CYC_DEF,
   parameter int PULSE_CYC    = PULSE_CYC_DEF,
   parameter int SETTLE_CYC   = SETTLE_CYC_DEF,
   parameter int ALWAYS_RESET = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [CNT_W-1:0] req_addr,
   input  logic             req_ena,
   output logic             ctrl_sel_rst_n,
   output logic             ctrl_sel_inc,
   output logic             ctrl_ena,
   output logic [CNT_W-1:0] cur_addr,
   output logic             busy
);

   localparam int TMR_W = tmr_width(RST_CYC, PULSE_CYC, SETTLE_CYC);

   sel_state_e       state_q, state_d;
   logic [CNT_W-1:0] tgt_q, tgt_d, cur_q, cur_d, n_q, n_d;
   logic             ena_tgt_q, ena_tgt_d;
   logic             rst_n_q, rst_n_d, inc_q, inc_d, ena_q, ena_d;
   logic             busy_q, busy_d, ready_q, ready_d;
   logic             accept, tmr_load, tmr_done;
   logic [TMR_W-1:0] tmr_val;

   assign accept = req_valid && ready_q;

   tt_sel_timer #(.TMR_W(TMR_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_RST_HOLD;
         tgt_q     <= '0;
         cur_q     <= '0;
         n_q       <= '0;
         ena_tgt_q <= 1'b0;
         rst_n_q   <= 1'b0;
         inc_q     <= 1'b0;
         ena_q     <= 1'b0;
         busy_q    <= 1'b1;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         tgt_q     <= tgt_d;
         cur_q     <= cur_d;
         n_q       <= n_d;
         ena_tgt_q <= ena_tgt_d;
         rst_n_q   <= rst_n_d;
         inc_q     <= inc_d;
         ena_q     <= ena_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:     if (accept && req_addr != cur_q) state_d = ST_DIS;
         ST_DIS:      if (tmr_done) state_d = (ALWAYS_RESET != 0 || tgt_q < cur_q) ? ST_RST : ST_INC_L;
         ST_RST:      if (tmr_done) state_d = (tgt_q == '0) ? ST_SETTLE : ST_INC_L;
         ST_INC_L:    if (tmr_done) state_d = ST_INC_H;
         ST_INC_H:    if (tmr_done) state_d = (n_q == '0) ? ST_SETTLE : ST_INC_L;
         ST_SETTLE:   if (tmr_done) state_d = ST_IDLE;
         ST_RST_HOLD: state_d = ST_IDLE;
         default:     state_d = ST_RST_HOLD;
      endcase
   end

   // Outputs are a registered function of the next state, so nothing
   // combinational reaches the pins.
   always_comb begin
      tgt_d     = tgt_q;
      cur_d     = cur_q;
      n_d       = n_q;
      ena_tgt_d = ena_tgt_q;
      ena_d     = ena_q;
      if (state_q == ST_IDLE && accept) begin
         tgt_d     = req_addr;
         ena_tgt_d = req_ena;
         if (req_addr == cur_q) ena_d = req_ena;
      end
      if (state_q == ST_DIS && state_d == ST_INC_L) n_d = tgt_q - cur_q;
      if (state_d == ST_RST && state_q != ST_RST) begin
         cur_d = '0;
         n_d   = tgt_q;
      end
      if (state_d == ST_INC_H && state_q != ST_INC_H) begin
         cur_d = cur_q + 1'b1;
         n_d   = n_q - 1'b1;
      end
      if (state_q == ST_SETTLE && state_d == ST_IDLE) ena_d = ena_tgt_q;
      if (state_d != ST_IDLE) ena_d = 1'b0;
      rst_n_d  = !(state_d == ST_RST || state_d == ST_RST_HOLD);
      inc_d    = (state_d == ST_INC_H);
      busy_d   = (state_d != ST_IDLE);
      ready_d  = (state_d == ST_IDLE);
      tmr_load = (state_d != state_q);
      unique case (state_d)
         ST_DIS, ST_SETTLE: tmr_val = TMR_W'(SETTLE_CYC - 1);
         ST_RST:            tmr_val = TMR_W'(RST_CYC - 1);
         ST_INC_L, ST_INC_H: tmr_val = TMR_W'(PULSE_CYC - 1);
         default:           tmr_val = '0;
      endcase
   end

   assign req_ready      = ready_q;
   assign ctrl_sel_rst_n = rst_n_q;
   assign ctrl_sel_inc   = inc_q;
   assign ctrl_ena       = ena_q;
   assign cur_addr       = cur_q;
   assign busy           = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_sel_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_tt_sel_seq : self-checking bench for tt_sel_seq against a timing model
// rev 1.0
// ------------------------------------------------------------------
module tb_tt_sel_seq;

   localparam int R = 4;
   localparam int P = 2;
   localparam int S = 4;
   localparam int BOUND = 5000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [1:0]      req_valid, req_ena, req_ready, rstn, inc, ena, busy;
   logic [1:0][9:0] req_addr, cur;
   int tests = 0;
   int failed = 0;
   int model_cur[2];

   tt_sel_seq #(.CNT_W(10), .RST_CYC(R), .PULSE_CYC(P), .SETTLE_CYC(S), .ALWAYS_RESET(0)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_addr(req_addr[0]), .req_ena(req_ena[0]), .ctrl_sel_rst_n(rstn[0]),
      .ctrl_sel_inc(inc[0]), .ctrl_ena(ena[0]), .cur_addr(cur[0]), .busy(busy[0])
   );

   tt_sel_seq #(.CNT_W(10), .RST_CYC(R), .PULSE_CYC(P), .SETTLE_CYC(S), .ALWAYS_RESET(1)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_addr(req_addr[1]), .req_ena(req_ena[1]), .ctrl_sel_rst_n(rstn[1]),
      .ctrl_sel_inc(inc[1]), .ctrl_ena(ena[1]), .cur_addr(cur[1]), .busy(busy[1])
   );

   // Expected latency (accept edge counted as 1), pulse count and reset-low
   // cycles for a request, from the shadow address the bench tracks.
   function automatic void model_req(input int d, input int addr,
                                     output int lat, output int n, output int rlow);
      int  c;
      bit  use_rst;
      c = model_cur[d];
      if (addr == c) begin
         lat = 1; n = 0; rlow = 0;
      end else begin
         use_rst = (d == 1) || (addr < c);
         n    = use_rst ? addr : addr - c;
         rlow = use_rst ? R : 0;
         lat  = 1 + S + rlow + 2 * P * n + S;
      end
      model_cur[d] = addr;
   endfunction

   // Issues one request and observes it until the DUT is idle again.
   task automatic run_req(input int d, input int addr, input bit e, input bit disturb,
                          output int lat, output int pulses, output int rlow,
                          output int viol, output logic [9:0] cur_o, output logic ena_o);
      int waitc;
      bit prev;
      lat = -1; pulses = 0; rlow = 0; viol = 0; cur_o = 'x; ena_o = 1'bx;
      waitc = 0;
      while (req_ready[d] !== 1'b1 && waitc < BOUND) begin
         @(posedge clk); #1;
         waitc++;
      end
      if (waitc >= BOUND) return;
      req_valid[d] = 1'b1;
      req_addr[d]  = 10'(addr);
      req_ena[d]   = e;
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      prev = 1'b0;
      for (int k = 0; k < BOUND; k++) begin
         if (inc[d] && !prev) pulses++;
         prev = inc[d];
         if (!rstn[d]) rlow++;
         if (inc[d] && !rstn[d]) viol++;
         if (busy[d] && ena[d]) viol++;
         if (busy[d] === 1'b0 && req_ready[d] === 1'b1) begin
            lat = k + 1; cur_o = cur[d]; ena_o = ena[d];
            break;
         end
         if (busy[d] !== 1'b1 || req_ready[d] !== 1'b0) viol++;
         if (disturb) begin
            req_valid[d] = 1'($urandom);
            req_addr[d]  = 10'($urandom);
            req_ena[d]   = 1'($urandom);
         end
         @(posedge clk); #1;
      end
      req_valid[d] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({rstn[d], inc[d], ena[d], busy[d], req_ready[d]} !== 5'b00010) begin
            failed++; $display("FAIL reset_ctrl dut%0d: rst_n/inc/ena/busy/ready=%b expected 00010", d, {rstn[d], inc[d], ena[d], busy[d], req_ready[d]});
         end
         tests++;
         if (cur[d] !== 10'd0) begin failed++; $display("FAIL reset_cur dut%0d: got %0d expected 0", d, cur[d]); end
      end
      rst = 1'b0;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         tests++;
         if ({rstn[d], inc[d], ena[d], busy[d], req_ready[d]} !== 5'b10001) begin
            failed++; $display("FAIL reset_release dut%0d: rst_n/inc/ena/busy/ready=%b expected 10001", d, {rstn[d], inc[d], ena[d], busy[d], req_ready[d]});
         end
      end
      model_cur[0] = 0; model_cur[1] = 0;
   endtask

   // One request with full checking; used by every request-level scenario.
   task automatic do_checked(input string name, input int d, input int addr, input bit e, input bit disturb);
      int lat, p, rl, v, el, en, erl;
      logic [9:0] c;
      logic eo;
      model_req(d, addr, el, en, erl);
      run_req(d, addr, e, disturb, lat, p, rl, v, c, eo);
      tests++; if (lat !== el) begin failed++; $display("FAIL %s latency addr=%0d: got %0d expected %0d", name, addr, lat, el); end
      tests++; if (p !== en) begin failed++; $display("FAIL %s inc_edges addr=%0d: got %0d expected %0d", name, addr, p, en); end
      tests++; if (rl !== erl) begin failed++; $display("FAIL %s rst_low addr=%0d: got %0d expected %0d", name, addr, rl, erl); end
      tests++; if (v !== 0) begin failed++; $display("FAIL %s invariants addr=%0d: got %0d violations expected 0", name, addr, v); end
      tests++; if (c !== 10'(addr)) begin failed++; $display("FAIL %s cur_addr: got %0d expected %0d", name, c, addr); end
      tests++; if (eo !== e) begin failed++; $display("FAIL %s ctrl_ena addr=%0d: got %b expected %b", name, addr, eo, e); end
   endtask

   task automatic test_count_up();
      do_checked("count_up", 0, 3, 1'b1, 1'b0);
   endtask

   task automatic test_reset_path();
      do_checked("reset_path", 0, 1, 1'b1, 1'b0);
   endtask

   task automatic test_same_addr();
      do_checked("same_addr_setup", 0, 5, 1'b1, 1'b0);
      do_checked("same_addr", 0, 5, 1'b0, 1'b0);
   endtask

   task automatic test_full_range();
      int tbl[3] = '{0, 1023, 0};
      foreach (tbl[i]) do_checked("full_range", 0, tbl[i], 1'($urandom), 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) do_checked("random", 0, int'($urandom_range(0, 24)), 1'($urandom), 1'b0);
   endtask

   task automatic test_busy_ignore();
      int a;
      a = (model_cur[0] < 1000) ? model_cur[0] + 3 : 2;
      do_checked("busy_ignore", 0, a, 1'b1, 1'b1);
   endtask

   task automatic test_mid_reset();
      int rises;
      bit prev, hit;
      do_checked("mid_reset_setup", 0, 0, 1'b1, 1'b0);
      req_valid[0] = 1'b1; req_addr[0] = 10'd5; req_ena[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      rises = 0; prev = 1'b0; hit = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (inc[0] && !prev) rises++;
         prev = inc[0];
         if (rises == 2 && inc[0]) begin hit = 1'b1; break; end
         @(posedge clk); #1;
      end
      tests++; if (hit !== 1'b1) begin failed++; $display("FAIL mid_reset_reach_pulse2: got %0d rises expected 2", rises); end
      rst = 1'b1;
      @(posedge clk); #1;
      tests++;
      if ({rstn[0], inc[0], ena[0], busy[0], req_ready[0]} !== 5'b00010) begin
         failed++; $display("FAIL mid_reset_ctrl: rst_n/inc/ena/busy/ready=%b expected 00010", {rstn[0], inc[0], ena[0], busy[0], req_ready[0]});
      end
      tests++; if (cur[0] !== 10'd0) begin failed++; $display("FAIL mid_reset_cur: got %0d expected 0", cur[0]); end
      rst = 1'b0;
      @(posedge clk); #1;
      tests++;
      if ({rstn[0], busy[0], req_ready[0]} !== 3'b101) begin
         failed++; $display("FAIL mid_reset_release: rst_n/busy/ready=%b expected 101", {rstn[0], busy[0], req_ready[0]});
      end
      model_cur[0] = 0; model_cur[1] = 0;
   endtask

   task automatic test_always_reset();
      do_checked("always_reset", 1, 2, 1'b1, 1'b0);
      do_checked("always_reset", 1, 4, 1'b1, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      req_valid = '0; req_ena = '0; req_addr = '0;
      test_reset();
      test_count_up();
      test_reset_path();
      test_same_addr();
      test_full_range();
      test_random();
      test_busy_ignore();
      test_mid_reset();
      test_always_reset();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
